// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters using round-robin
// arbitration. A granted request has its operands and opcode registered and
// driven to the ALU. The result is captured one cycle later and returned on a
// valid/ready response channel, tagged with the requester ID.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_valid_k, i_data_a_k,
//   i_data_b_k, i_op_k          request from requester k (k = 0, 1)
//   o_ready_k                   request k accepted on an edge where valid&&ready
//   o_alu_data_a/b, o_alu_op    registered operands and opcode to the ALU
//   i_alu_result                combinational ALU result
//   o_rsp_valid/id/result/err   response; err flags an illegal opcode
//   i_rsp_ready                 consumer takes the response on valid&&ready
//   o_busy                      FSM is not idle
module alu_arbiter #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid_0,
    input  logic [NB_DATA-1:0] i_data_a_0,
    input  logic [NB_DATA-1:0] i_data_b_0,
    input  logic [NB_OP-1:0]   i_op_0,
    input  logic               i_valid_1,
    input  logic [NB_DATA-1:0] i_data_a_1,
    input  logic [NB_DATA-1:0] i_data_b_1,
    input  logic [NB_OP-1:0]   i_op_1,
    output logic               o_ready_0,
    output logic               o_ready_1,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_rsp_valid,
    output logic               o_rsp_id,
    output logic [NB_DATA-1:0] o_rsp_result,
    output logic               o_rsp_err,
    input  logic               i_rsp_ready,
    output logic               o_busy
);

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;           // requester favoured on contention
    logic               id_q, id_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [NB_DATA-1:0] rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;
    logic               op_legal;
    logic               grant_0, grant_1;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    // Grants are purely combinational so a valid that rises on the cycle the
    // FSM returns to IDLE is granted in that same cycle.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state_q == IDLE && !i_reset) begin
            if (i_valid_0 && i_valid_1) begin
                grant_0 = !ptr_q;
                grant_1 = ptr_q;
            end else begin
                grant_0 = i_valid_0;
                grant_1 = i_valid_1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_0) begin
                    a_d     = i_data_a_0;
                    b_d     = i_data_b_0;
                    op_d    = i_op_0;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = EXEC;
                end else if (grant_1) begin
                    a_d     = i_data_a_1;
                    b_d     = i_data_b_1;
                    op_d    = i_op_1;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Illegal opcodes still complete, but never leak the ALU's
                // undefined output.
                rsp_result_d = op_legal ? i_alu_result : '0;
                rsp_err_d    = !op_legal;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign o_ready_0    = grant_0;
    assign o_ready_1    = grant_1;
    assign o_alu_data_a = a_q;
    assign o_alu_data_b = b_q;
    assign o_alu_op     = op_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the external ALU, runs a table of single
// requests and hand-written sequences for arbitration, backpressure and reset.
module tb_alu_arbiter;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR_ = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;

    logic       clk;
    logic       rst;
    logic       v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic [5:0] op0, op1;
    logic       rdy0, rdy1;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [5:0] alu_op;
    logic       rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
    logic [7:0] rsp_result;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_valid_0(v0), .i_data_a_0(a0), .i_data_b_0(b0), .i_op_0(op0),
        .i_valid_1(v1), .i_data_a_1(a1), .i_data_b_1(b1), .i_op_1(op1),
        .o_ready_0(rdy0), .o_ready_1(rdy1),
        .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_res),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
        .o_rsp_err(rsp_err), .i_rsp_ready(rsp_ready), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; illegal codes return junk that must not reach the response.
    always_comb begin
        case (alu_op)
            ADD:     alu_res = alu_a + alu_b;
            SUB:     alu_res = alu_a - alu_b;
            AND:     alu_res = alu_a & alu_b;
            OR_:     alu_res = alu_a | alu_b;
            XOR:     alu_res = alu_a ^ alu_b;
            NOR:     alu_res = ~(alu_a | alu_b);
            SRA:     alu_res = 8'($signed(alu_a) >>> alu_b);
            SRL:     alu_res = alu_a >> alu_b;
            default: alu_res = 8'hAA;
        endcase
    end

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [5:0] op);
        if (id == 1'b0) begin
            v0 = v; a0 = a; b0 = b; op0 = op;
        end else begin
            v1 = v; a1 = a; b1 = b; op1 = op;
        end
    endtask

    task automatic chk_rsp(input string name, input logic id, input logic [7:0] res,
                           input logic err);
        chk({name, ".rsp_valid"}, rsp_valid, 1);
        chk({name, ".rsp_id"}, rsp_id, id);
        chk({name, ".rsp_result"}, rsp_result, res);
        chk({name, ".rsp_err"}, rsp_err, err);
    endtask

    // Single request from an idle FSM with i_rsp_ready held high.
    task automatic run_vec(input int idx, input vec_t v);
        string n;
        n = $sformatf("vec%0d", idx);
        set_req(v.id, 1'b1, v.a, v.b, v.op);
        @(negedge clk);
        chk({n, ".ready"}, {rdy1, rdy0}, v.id ? 2'b10 : 2'b01);
        chk({n, ".busy_idle"}, busy, 0);
        step();
        set_req(v.id, 1'b0, 8'h00, 8'h00, 6'h00);
        @(negedge clk);
        chk({n, ".exec_busy"}, busy, 1);
        chk({n, ".exec_rsp_valid"}, rsp_valid, 0);
        chk({n, ".exec_ready"}, {rdy1, rdy0}, 0);
        chk({n, ".alu_ops"}, {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
        step();
        @(negedge clk);
        chk_rsp(n, v.id, v.res, v.err);
        step();
        @(negedge clk);
        chk({n, ".done_valid"}, rsp_valid, 0);
        chk({n, ".done_busy"}, busy, 0);
        chk({n, ".alu_held"}, {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'd25,  8'd17,  ADD,      8'd42,  1'b0};
        vecs[1]  = '{1'b1, 8'd5,   8'd9,   SUB,      8'hFC,  1'b0};
        vecs[2]  = '{1'b0, 8'hF0,  8'h3C,  AND,      8'h30,  1'b0};
        vecs[3]  = '{1'b1, 8'hF0,  8'h3C,  OR_,      8'hFC,  1'b0};
        vecs[4]  = '{1'b0, 8'hF0,  8'h3C,  XOR,      8'hCC,  1'b0};
        vecs[5]  = '{1'b1, 8'hF0,  8'h3C,  NOR,      8'h03,  1'b0};
        vecs[6]  = '{1'b0, 8'h80,  8'h01,  SRA,      8'hC0,  1'b0};
        vecs[7]  = '{1'b1, 8'h80,  8'h01,  SRL,      8'h40,  1'b0};
        vecs[8]  = '{1'b0, 8'h7F,  8'h01,  ADD,      8'h80,  1'b0};
        vecs[9]  = '{1'b1, 8'h12,  8'h34,  6'b111111, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 8'h12,  8'h34,  6'b000000, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 8'h00,  8'h01,  SUB,      8'hFF,  1'b0};

        rst = 1'b1; rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'd5, 8'd9, SUB);
        set_req(1'b1, 1'b1, 8'hF0, 8'h3C, AND);

        // Reset: everything zero, no grants even with both valids high.
        step();
        step();
        @(negedge clk);
        chk("reset.ready", {rdy1, rdy0}, 0);
        chk("reset.alu", {alu_a, alu_b, alu_op}, 0);
        chk("reset.rsp", {rsp_valid, rsp_id, rsp_result, rsp_err}, 0);
        chk("reset.busy", busy, 0);
        step();
        rst = 1'b0;

        // Contention: req0 first; req0 re-requests while req1 waits, so the
        // next pair goes to req1, then req0.
        @(negedge clk);
        chk("pair.ready_a", {rdy1, rdy0}, 2'b01);
        step();
        set_req(1'b0, 1'b1, 8'hF0, 8'h3C, XOR);
        @(negedge clk);
        chk("pair.exec_ready", {rdy1, rdy0}, 0);
        step();
        @(negedge clk);
        chk_rsp("pair.r0", 1'b0, 8'hFC, 1'b0);
        step();
        @(negedge clk);
        chk("pair.ready_b", {rdy1, rdy0}, 2'b10);
        step();
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
        step();
        @(negedge clk);
        chk_rsp("pair.r1", 1'b1, 8'h30, 1'b0);
        step();
        @(negedge clk);
        chk("pair.ready_c", {rdy1, rdy0}, 2'b01);
        step();
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        step();
        @(negedge clk);
        chk_rsp("pair.r0b", 1'b0, 8'hCC, 1'b0);
        step();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Backpressure with both valids high, starting from pointer 0.
        rst = 1'b1;
        step();
        rst = 1'b0; rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'd25, 8'd17, ADD);
        set_req(1'b1, 1'b1, 8'd5, 8'd9, SUB);
        @(negedge clk);
        chk("bp.ready", {rdy1, rdy0}, 2'b01);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_rsp($sformatf("bp.hold%0d", i), 1'b0, 8'd42, 1'b0);
            chk($sformatf("bp.ready%0d", i), {rdy1, rdy0}, 0);
            chk($sformatf("bp.busy%0d", i), busy, 1);
            chk($sformatf("bp.alu%0d", i), {alu_a, alu_b, alu_op}, {8'd25, 8'd17, ADD});
            step();
        end
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp.release", {busy, rsp_valid}, 0);
        chk("bp.ready_next", {rdy1, rdy0}, 2'b10);
        step();
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
        step();
        @(negedge clk);
        chk_rsp("bp.r1", 1'b1, 8'hFC, 1'b0);
        step();
        step();

        // Reset while in EXEC discards the request and clears the pointer.
        set_req(1'b0, 1'b1, 8'd25, 8'd17, ADD);
        step();
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("rexec.ready_in_rst", {rdy1, rdy0}, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rexec.alu", {alu_a, alu_b, alu_op}, 0);
        chk("rexec.rsp", {rsp_valid, rsp_id, rsp_result, rsp_err}, 0);
        chk("rexec.busy", busy, 0);
        set_req(1'b0, 1'b1, 8'd25, 8'd17, ADD);
        set_req(1'b1, 1'b1, 8'hF0, 8'h3C, AND);
        #1;
        chk("rexec.ptr0", {rdy1, rdy0}, 2'b01);
        step();
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
        step();
        @(negedge clk);
        chk_rsp("rexec.r0", 1'b0, 8'd42, 1'b0);
        step();
        step();
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
        step();
        @(negedge clk);
        chk_rsp("rexec.r1", 1'b1, 8'h30, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
